// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer.
// Holds the FSM state enum, remote opcodes and the default ACK byte.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_CMD,
        SEND_DAT,
        WAIT_DAT,
        WAIT_RESP,
        CHECK
    } state_t;

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] SET_CAL   = 8'h06;
    localparam logic [7:0] SET_EMGL  = 8'h07;
    localparam logic [7:0] SET_MOFF  = 8'h08;

    localparam logic [7:0] ACK_DEF = 8'hA5;

endpackage

// File: rtl/cmd_seq_fifo.sv
// Circular command queue, DEPTH x W, pointer pair with wrap bit.
// Ports: wr/wr_data push, pop/rd_data head, flush empties, full/empty, ovfl sticky.
module cmd_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         ovfl
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic [W-1:0] mem [DEPTH];
    logic         rd_ok;
    logic         wr_ok;

    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign rd_ok   = pop && !empty && !flush;
    // A pop in the same cycle frees the slot, so a write to a full queue still lands.
    assign wr_ok   = wr && !flush && (!full || rd_ok);
    assign rd_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            ovfl <= 1'b0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            if (wr && !wr_ok) ovfl <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cmd_seq_master.sv
// Queued command master: sends opcode + payload over a byte UART, checks ACK, retries.
// Ports: cmd_in/data_in/cmd_wr enqueue, abort flush, tx_* / rx_* UART side, status outputs.
module cmd_seq_master
    import cmd_seq_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         DATA_BYTES  = 2,
    parameter logic [7:0] ACK_VAL     = ACK_DEF,
    parameter int         TIMEOUT_CYC = 1048576,
    parameter int         MAX_RETRY   = 2,
    // With no payload the data port keeps one unused byte so it never has zero width.
    localparam int        PW          = (DATA_BYTES > 0) ? 8 * DATA_BYTES : 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    cmd_in,
    input  logic [PW-1:0] data_in,
    input  logic          cmd_wr,
    input  logic          abort,
    output logic          q_full,
    output logic          q_empty,
    output logic [7:0]    tx_data,
    output logic          trmt,
    input  logic          tx_done,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          clr_rx_rdy,
    output logic          busy,
    output logic          cmd_ok,
    output logic          cmd_err,
    output logic [7:0]    last_resp,
    output logic          ovfl,
    output logic [7:0]    err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    localparam logic [2:0]    LAST = 3'((DATA_BYTES > 0) ? DATA_BYTES - 1 : 0);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [RW-1:0] retry, retry_n;
    logic [2:0]    byte_idx, idx_n;
    logic          resp_ok, resp_ok_n;
    logic          owed, owed_n;
    logic [7:0]    tx_data_n, last_n, err_cnt_n;
    logic          trmt_n, clr_n, ok_n, err_n, busy_n;
    logic          pop, rx_new, done;
    logic [PW+7:0] head;
    logic [7:0]    head_op;
    logic [PW-1:0] head_dat, dat_sh;

    cmd_seq_fifo #(
        .DEPTH(DEPTH),
        .W    (PW + 8)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (cmd_wr),
        .wr_data({cmd_in, data_in}),
        .pop    (pop),
        .flush  (abort),
        .rd_data(head),
        .full   (q_full),
        .empty  (q_empty),
        .ovfl   (ovfl)
    );

    assign head_op  = head[PW+7:PW];
    assign head_dat = head[PW-1:0];
    assign dat_sh   = head_dat << {byte_idx, 3'b000};
    // rx_rdy is still high in the cycle our clear is on the wire; ignore it then.
    assign rx_new   = rx_rdy && !clr_rx_rdy;
    // owed marks a byte left running by abort; its tx_done belongs to nobody.
    assign done     = tx_done && !owed;

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        retry_n   = retry;
        idx_n     = byte_idx;
        resp_ok_n = resp_ok;
        owed_n    = owed;
        tx_data_n = tx_data;
        last_n    = last_resp;
        err_cnt_n = err_cnt;
        trmt_n    = 1'b0;
        clr_n     = 1'b0;
        ok_n      = 1'b0;
        err_n     = 1'b0;
        pop       = 1'b0;
        if (tx_done) owed_n = 1'b0;
        if (abort) begin
            state_n = IDLE;
            timer_n = '0;
            retry_n = '0;
            idx_n   = '0;
            if ((state == WAIT_CMD || state == WAIT_DAT) && !tx_done)
                owed_n = 1'b1;
            if (rx_new) clr_n = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!q_empty && !owed) state_n = SEND_CMD;
                end
                SEND_CMD: begin
                    trmt_n    = 1'b1;
                    tx_data_n = head_op;
                    state_n   = WAIT_CMD;
                end
                WAIT_CMD: begin
                    if (done) begin
                        if (DATA_BYTES == 0) begin
                            state_n = WAIT_RESP;
                            timer_n = '0;
                        end else begin
                            state_n = SEND_DAT;
                        end
                    end
                end
                SEND_DAT: begin
                    trmt_n    = 1'b1;
                    tx_data_n = dat_sh[PW-1 -: 8];
                    state_n   = WAIT_DAT;
                end
                WAIT_DAT: begin
                    if (done) begin
                        idx_n = byte_idx + 3'd1;
                        if (byte_idx == LAST) begin
                            state_n = WAIT_RESP;
                            timer_n = '0;
                        end else begin
                            state_n = SEND_DAT;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (rx_new) begin
                        last_n    = rx_data;
                        clr_n     = 1'b1;
                        resp_ok_n = (rx_data == ACK_VAL);
                        state_n   = CHECK;
                    end else if (timer == TMAX) begin
                        resp_ok_n = 1'b0;
                        state_n   = CHECK;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                CHECK: begin
                    idx_n = '0;
                    if (resp_ok) begin
                        ok_n    = 1'b1;
                        pop     = 1'b1;
                        retry_n = '0;
                        state_n = IDLE;
                    end else if (retry < RMAX) begin
                        retry_n = retry + 1'b1;
                        state_n = SEND_CMD;
                    end else begin
                        err_n     = 1'b1;
                        pop       = 1'b1;
                        retry_n   = '0;
                        err_cnt_n = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (state != WAIT_RESP && rx_new) clr_n = 1'b1;
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            retry      <= '0;
            byte_idx   <= '0;
            resp_ok    <= 1'b0;
            owed       <= 1'b0;
            tx_data    <= '0;
            trmt       <= 1'b0;
            clr_rx_rdy <= 1'b0;
            busy       <= 1'b0;
            cmd_ok     <= 1'b0;
            cmd_err    <= 1'b0;
            last_resp  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            retry      <= retry_n;
            byte_idx   <= idx_n;
            resp_ok    <= resp_ok_n;
            owed       <= owed_n;
            tx_data    <= tx_data_n;
            trmt       <= trmt_n;
            clr_rx_rdy <= clr_n;
            busy       <= busy_n;
            cmd_ok     <= ok_n;
            cmd_err    <= err_n;
            last_resp  <= last_n;
            err_cnt    <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_cmd_seq_master.sv
// Directed bench for cmd_seq_master with a byte-level UART model and scoreboard.
// Expected tx bytes and responses are queued as stimulus is driven.
module tb_cmd_seq_master;
    import cmd_seq_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_in = '0;
    logic [15:0] data_in = '0;
    logic        cmd_wr = 1'b0;
    logic        abort = 1'b0;
    logic        q_full, q_empty, trmt, clr_rx_rdy, busy;
    logic        cmd_ok, cmd_err, ovfl;
    logic [7:0]  tx_data, last_resp, err_cnt;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;

    always #5 clk = ~clk;

    cmd_seq_master #(
        .DEPTH      (4),
        .DATA_BYTES (2),
        .ACK_VAL    (8'hA5),
        .TIMEOUT_CYC(TO),
        .MAX_RETRY  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_in    (cmd_in),
        .data_in   (data_in),
        .cmd_wr    (cmd_wr),
        .abort     (abort),
        .q_full    (q_full),
        .q_empty   (q_empty),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .tx_done   (tx_done),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .clr_rx_rdy(clr_rx_rdy),
        .busy      (busy),
        .cmd_ok    (cmd_ok),
        .cmd_err   (cmd_err),
        .last_resp (last_resp),
        .ovfl      (ovfl),
        .err_cnt   (err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int tcnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] resp_q[$];
    int gap_q[$];
    int n_trmt = 0, n_ok = 0, n_err = 0, n_clr = 0;
    int pos = 0, tx_cnt = 0, resp_wait = 0;
    bit last_pend = 0, fin_valid = 0;
    int t_fin = 0, t_trmt = 0, t_wr = 0, err_gap = -1;
    int b_trmt, b_ok, b_err, b_clr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample DUT at negedge, advance UART tx/rx model.
    task automatic tick();
        @(negedge clk);
        tcnt++;
        if (abort) begin
            pos = 0;
            last_pend = 0;
        end
        if (clr_rx_rdy) begin
            n_clr++;
            rx_rdy = 1'b0;
        end
        if (cmd_ok) begin
            n_ok++;
            fin_valid = 0;
        end
        if (cmd_err) begin
            n_err++;
            err_gap = fin_valid ? tcnt - t_fin : -1;
            fin_valid = 0;
        end
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                if (last_pend) begin
                    last_pend = 0;
                    t_fin = tcnt;
                    fin_valid = 1;
                    resp_wait = 3;
                end
            end
        end
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0 && resp_q.size() > 0) begin
                rx_data = resp_q.pop_front();
                rx_rdy = 1'b1;
            end
        end
        if (trmt) begin
            n_trmt++;
            t_trmt = tcnt;
            if (pos == 0 && fin_valid) begin
                gap_q.push_back(tcnt - t_fin);
                fin_valid = 0;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL tx_unexpected: observed %0h expected none", tx_data);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            tx_cnt = 4;
            pos++;
            if (pos == 3) begin
                last_pend = 1;
                pos = 0;
            end
        end
    endtask

    task automatic enq(logic [7:0] op, logic [15:0] d, int sends);
        cmd_in = op;
        data_in = d;
        cmd_wr = 1'b1;
        t_wr = tcnt;
        for (int i = 0; i < sends; i++) begin
            exp_q.push_back(op);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
        end
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic wait_done(int want_ok, int want_err, int budget, string tag);
        int n = 0;
        while ((n_ok < want_ok || n_err < want_err) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (n_ok >= want_ok && n_err >= want_err)}, 32'd1);
    endtask

    task automatic wait_trmt(int want, int budget, string tag);
        int n = 0;
        while (n_trmt < want && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (n_trmt >= want)}, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_outs", {trmt, clr_rx_rdy, busy, cmd_ok, cmd_err, ovfl, q_full}, 0);
        chk("rst_bytes", {8'd0, tx_data, last_resp, err_cnt}, 0);
        chk("rst_empty", {31'd0, q_empty}, 1);
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 0);

        // Single command, immediate ACK.
        b_trmt = n_trmt;
        resp_q.push_back(8'hA5);
        enq(SET_THRST, 16'h00FF, 1);
        wait_trmt(b_trmt + 1, 20, "t1_start");
        // cmd_wr sampled at the next edge; trmt rises two edges after that.
        chk("t1_latency", t_trmt - t_wr, 3);
        wait_done(1, 0, 200, "t1_done");
        chk("t1_empty", {31'd0, q_empty}, 1);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_resp", {24'd0, last_resp}, 8'hA5);
        repeat (10) tick();
        chk("t1_ok_once", n_ok, 1);
        chk("t1_trmt", n_trmt - b_trmt, 3);

        // Two NAKs then ACK: three full frames.
        b_trmt = n_trmt;
        resp_q.push_back(8'h5A);
        resp_q.push_back(8'h5A);
        resp_q.push_back(8'hA5);
        enq(SET_PTCH, 16'h0100, 3);
        wait_done(2, 0, 400, "t2_done");
        chk("t2_trmt", n_trmt - b_trmt, 9);
        chk("t2_errcnt", {24'd0, err_cnt}, 0);
        chk("t2_noerr", n_err, 0);
        repeat (5) tick();

        // No response: three timeouts then cmd_err.
        gap_q.delete();
        b_trmt = n_trmt;
        enq(SET_EMGL, 16'h1234, 3);
        wait_done(2, 1, 1000, "t3_done");
        chk("t3_trmt", n_trmt - b_trmt, 9);
        chk("t3_gaps", gap_q.size(), 2);
        // tx_done -> 64 cycles WAIT_RESP -> CHECK -> SEND_CMD -> trmt visible.
        for (int i = 0; i < gap_q.size(); i++)
            chk("t3_gap", gap_q[i], TO + 3);
        chk("t3_err_gap", err_gap, TO + 2);
        chk("t3_errcnt", {24'd0, err_cnt}, 1);
        chk("t3_resp_kept", {24'd0, last_resp}, 8'hA5);
        chk("t3_ok_none", n_ok, 2);
        repeat (5) tick();

        // Fill a 4-deep queue while busy; fifth write overflows.
        b_ok = n_ok;
        repeat (4) resp_q.push_back(8'hA5);
        enq(SET_ROLL, 16'h0A0B, 1);
        enq(SET_YAW, 16'h0C0D, 1);
        enq(SET_CAL, 16'h0E0F, 1);
        chk("t4_notfull", {30'd0, q_full, ovfl}, 0);
        enq(SET_MOFF, 16'h1011, 1);
        chk("t4_full", {31'd0, q_full}, 1);
        chk("t4_busy", {31'd0, busy}, 1);
        enq(SET_THRST, 16'h9999, 0);
        chk("t4_ovfl", {31'd0, ovfl}, 1);
        wait_done(b_ok + 4, 1, 600, "t4_done");
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_q_empty", {31'd0, q_empty}, 1);
        repeat (10) tick();
        chk("t4_ok_count", n_ok - b_ok, 4);

        // Abort after the first data byte has been handed to the UART.
        b_trmt = n_trmt;
        b_ok = n_ok;
        b_err = n_err;
        cmd_in = SET_YAW;
        data_in = 16'hABCD;
        cmd_wr = 1'b1;
        exp_q.push_back(SET_YAW);
        exp_q.push_back(8'hAB);
        tick();
        cmd_wr = 1'b0;
        wait_trmt(b_trmt + 2, 50, "t5_reach");
        abort = 1'b1;
        cmd_in = SET_CAL;
        cmd_wr = 1'b1;
        tick();
        abort = 1'b0;
        cmd_wr = 1'b0;
        repeat (40) tick();
        chk("t5_no_trmt", n_trmt - b_trmt, 2);
        chk("t5_empty", {31'd0, q_empty}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_no_pulse", (n_ok - b_ok) + (n_err - b_err), 0);
        b_trmt = n_trmt;
        resp_q.push_back(8'hA5);
        enq(SET_CAL, 16'h1357, 1);
        wait_done(b_ok + 1, b_err, 200, "t5_new_done");
        chk("t5_new_trmt", n_trmt - b_trmt, 3);
        repeat (5) tick();

        // Stale response byte while idle.
        b_clr = n_clr;
        rx_data = 8'h33;
        rx_rdy = 1'b1;
        repeat (5) tick();
        chk("t6_clr", n_clr - b_clr, 1);
        chk("t6_rx_low", {31'd0, rx_rdy}, 0);
        chk("t6_resp_kept", {24'd0, last_resp}, 8'hA5);
        b_ok = n_ok;
        resp_q.push_back(8'hA5);
        enq(SET_MOFF, 16'h0001, 1);
        wait_done(b_ok + 1, n_err, 200, "t6_done");
        chk("t6_resp", {24'd0, last_resp}, 8'hA5);

        repeat (10) tick();
        chk("end_sb", exp_q.size(), 0);
        chk("end_errcnt", {24'd0, err_cnt}, 1);
        chk("end_nerr", n_err, 1);
        chk("end_ovfl", {31'd0, ovfl}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_seq_master.md
Name: cmd_seq_master

Overview:
- Parametrised host-side command master: queues remote commands (opcode plus N data bytes) and serialises each onto a byte-wide UART transmit interface.
- After each command it waits for a 1-byte response, checks it against the ACK value, and retries on NAK or timeout.
- Sits between bench or host logic and the uart_tx/uart_rx pair, replacing the single-shot command sender.
- Supports multi-entry queueing, variable payload width, timeout, retry and abort.

Parameters:
- DEPTH, 8: command queue entries; power of two, minimum 2.
- DATA_BYTES, 2: payload bytes per command, range 0..4.
- ACK_VAL, 8'hA5: response byte that counts as success.
- TIMEOUT_CYC, 1048576: clocks to wait for a response after the last byte's tx_done.
- MAX_RETRY, 2: resends after the first attempt before declaring an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- cmd_in  in  8  opcode to enqueue.
- data_in  in  8*DATA_BYTES  payload to enqueue; the MS byte is sent first.
- cmd_wr  in  1  enqueue strobe, one cycle per entry.
- abort  in  1  flush the queue and return to IDLE.
- q_full  out  1  queue full.
- q_empty  out  1  queue empty.
- tx_data  out  8  byte to transmit.
- trmt  out  1  single-cycle transmit start.
- tx_done  in  1  transmitter finished the byte.
- rx_data  in  8  received byte.
- rx_rdy  in  1  received byte valid (level).
- clr_rx_rdy  out  1  single-cycle clear of rx_rdy.
- busy  out  1  a command is in flight.
- cmd_ok  out  1  pulse: head command was ACKed.
- cmd_err  out  1  pulse: head command failed after all retries.
- last_resp  out  8  last response byte received.
- ovfl  out  1  sticky: a write was attempted while full.
- err_cnt  out  8  count of failed commands, saturates at 255.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except q_empty=1. Queue pointers, retry count and timer are 0. State is IDLE.
- Queue: circular FIFO with pointers of clog2(DEPTH) bits plus a wrap bit.
  - cmd_wr while q_full drops the write and sets ovfl; ovfl clears only on rst.
  - cmd_wr and a pop in the same cycle while full: the write is accepted.
- The head entry is popped only on the cmd_ok or cmd_err cycle.
- FSM states: IDLE, SEND_CMD, WAIT_CMD, SEND_DAT, WAIT_DAT, WAIT_RESP, CHECK.
- IDLE: when q_empty=0, go to SEND_CMD and assert busy.
  - trmt (registered) pulses with tx_data=opcode 2 clocks after a cmd_wr into an empty idle queue.
- SEND_CMD: pulse trmt, go to WAIT_CMD.
- WAIT_CMD: on tx_done, go to SEND_DAT, or go to WAIT_RESP if DATA_BYTES=0.
  - Clear the timer on entry to WAIT_RESP.
- SEND_DAT: pulse trmt with tx_data = payload byte at index byte_idx (MS first), go to WAIT_DAT.
- WAIT_DAT: on tx_done, increment byte_idx. After the last byte, go to WAIT_RESP; otherwise go to SEND_DAT.
- WAIT_RESP: the timer counts each cycle.
  - On rx_rdy: latch rx_data into last_resp, pulse clr_rx_rdy, go to CHECK.
  - Timeout when the timer reaches TIMEOUT_CYC-1: go to CHECK with the result treated as a fail.
  - rx_rdy and timeout in the same cycle: rx_rdy wins.
- CHECK:
  - If the response equals ACK_VAL: pulse cmd_ok, pop, reset the retry count, go to IDLE.
  - Else if retry count < MAX_RETRY: increment it, reset byte_idx, go to SEND_CMD (resends the same entry).
  - Else: pulse cmd_err, increment err_cnt (saturating), pop, reset the retry count, go to IDLE.
- busy deasserts in IDLE.
- Stale rx_rdy seen in any state other than WAIT_RESP is cleared with a clr_rx_rdy pulse and ignored; last_resp does not update.
- abort has priority over everything except rst.
  - Empties the queue, returns to IDLE, clears the timer, retry count and byte_idx.
  - No cmd_ok or cmd_err pulse is generated.
  - A byte already handed to the UART completes on its own; its tx_done is ignored.
  - cmd_wr in the same cycle as abort is dropped.
- tx_data holds its value between trmt pulses.
- The timer width is clog2(TIMEOUT_CYC).

Decomposition:
- Shared package cmd_seq_pkg holds:
  - the state enum typedef;
  - command opcode localparams: SET_PTCH 8'h02, SET_ROLL 03, SET_YAW 04, SET_THRST 05, SET_CAL 06, SET_EMGL 07, SET_MOFF 08;
  - default ACK_VAL 8'hA5.
- One sub-module: cmd_seq_fifo, a parametrised DEPTH x (8+8*DATA_BYTES) queue with full/empty and an ovfl output.

Test Plan:
- Reset, then enqueue {05, 16'h00FF}. Required: trmt pulses 2 clocks later with 05, then 00, then FF, each after tx_done. Respond A5: cmd_ok pulses once, q_empty=1, busy=0, last_resp=A5.
- Enqueue {02, 0100}. Respond 5A, then 5A, then A5. Required: the 3-byte frame is sent 3 times, then cmd_ok. err_cnt stays 0.
- TIMEOUT_CYC=64, no response. Required: 3 transmissions, each WAIT_RESP exactly 64 clocks, then cmd_err pulses and err_cnt=1.
- DEPTH=4: 5 back-to-back cmd_wr while busy. Required: q_full after the 4th, 5th dropped, ovfl=1. All 4 accepted commands complete in order 03, 04, 06, 08.
- abort asserted mid-frame after the first data byte. Required: no further trmt, q_empty=1, busy=0, no cmd_ok/cmd_err pulse. A new enqueue afterwards sends a clean full frame.
- Stale rx_rdy with byte 33 while IDLE. Required: clr_rx_rdy pulses, last_resp unchanged. A following command still completes on A5.
